// File: rtl/mem_array_pkg.sv
// Shared types and default sizing for the mem_array block.
package mem_array_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_state_e;

    localparam int unsigned MEM_AW    = 5;
    localparam int unsigned MEM_DW    = 8;
    localparam int unsigned MEM_DEPTH = 32;
    localparam int unsigned MEM_ERRW  = 8;

endpackage

// File: rtl/mem_clear_seq.sv
// Post-reset clear sequencer: walks every address once, writing zero, then hands the array to the host.
module mem_clear_seq
    import mem_array_pkg::*;
#(
    parameter int unsigned DEPTH = MEM_DEPTH,
    parameter int unsigned AW    = MEM_AW
) (
    input  logic          clk,
    input  logic          rst,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam int unsigned LAST = DEPTH - 1;

    mem_state_e    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          busy_q;

    // State, pointer and busy flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= (state_d == CLEAR);
        end
    end

    // Next state: advance the pointer each cycle, leave CLEAR once the last word is written
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            CLEAR: begin
                if (ptr_q == AW'(LAST)) begin
                    state_d = READY;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    assign busy     = busy_q;
    assign clr_we   = busy_q;
    assign clr_addr = ptr_q;

endmodule

// File: rtl/mem_array.sv
// Single-port DEPTHxDW memory with self-clear after reset.
// Optional per-word parity storage and checking enabled by MEM_ARRAY_PARITY_EN.
module mem_array
    import mem_array_pkg::*;
#(
    parameter int unsigned DEPTH = MEM_DEPTH,
    parameter int unsigned AW    = MEM_AW,
    parameter int unsigned DW    = MEM_DW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                read,
    input  logic                write,
    input  logic [AW-1:0]       addr,
    input  logic [DW-1:0]       data_in,
    input  logic                inj_err,
    output logic [DW-1:0]       data_out,
    output logic                rd_valid,
    output logic                busy,
    output logic                par_err,
    output logic [MEM_ERRW-1:0] err_count,
    output logic [AW-1:0]       err_addr
);

    logic          clr_we;
    logic [AW-1:0] clr_addr;

    mem_clear_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    logic          host_en_c;
    logic          host_we_c;
    logic          host_re_c;
    logic          we_c;
    logic [AW-1:0] wa_c;
    logic [DW-1:0] wd_c;

    // Host strobes are blocked while clearing or in reset; a simultaneous read is dropped
    assign host_en_c = !busy && !rst;
    assign host_we_c = host_en_c && write;
    assign host_re_c = host_en_c && read && !write;

    assign we_c = clr_we || host_we_c;
    assign wa_c = clr_we ? clr_addr : addr;
    assign wd_c = clr_we ? '0 : data_in;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_c) begin
            mem[wa_c] <= wd_c;
        end
    end

    logic [DW-1:0] data_out_q;
    logic          rd_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= host_re_c;
            if (host_re_c) begin
                data_out_q <= mem[addr];
            end
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;

`ifdef MEM_ARRAY_PARITY_EN
    logic                par_mem [DEPTH];
    logic                par_wd_c;
    logic                rd_bad_c;
    logic                par_err_q;
    logic [MEM_ERRW-1:0] err_count_q;
    logic [AW-1:0]       err_addr_q;

    // Stored parity is the XOR of the data, optionally inverted to inject a fault
    assign par_wd_c = clr_we ? 1'b0 : ((^data_in) ^ inj_err);

    always_ff @(posedge clk) begin
        if (we_c) begin
            par_mem[wa_c] <= par_wd_c;
        end
    end

    assign rd_bad_c = (^mem[addr]) ^ par_mem[addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            par_err_q   <= 1'b0;
            err_count_q <= '0;
            err_addr_q  <= '0;
        end else begin
            par_err_q <= host_re_c && rd_bad_c;
            if (host_re_c && rd_bad_c) begin
                err_addr_q <= addr;
                if (err_count_q != '1) begin
                    err_count_q <= err_count_q + MEM_ERRW'(1);
                end
            end
        end
    end

    assign par_err   = par_err_q;
    assign err_count = err_count_q;
    assign err_addr  = err_addr_q;
`else
    logic unused_inj_err;

    assign unused_inj_err = inj_err;
    assign par_err        = 1'b0;
    assign err_count      = '0;
    assign err_addr       = '0;
`endif

endmodule

// File: tb/tb_mem_array.sv
// Directed scoreboard bench for mem_array: reset/clear, readback, parity, collision and saturation.
module tb_mem_array;
    import mem_array_pkg::*;

`ifdef MEM_ARRAY_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       read;
    logic       write;
    logic [4:0] addr;
    logic [7:0] data_in;
    logic       inj_err;
    logic [7:0] data_out;
    logic       rd_valid;
    logic       busy;
    logic       par_err;
    logic [7:0] err_count;
    logic [4:0] err_addr;

    mem_array dut (
        .clk       (clk),
        .rst       (rst),
        .read      (read),
        .write     (write),
        .addr      (addr),
        .data_in   (data_in),
        .inj_err   (inj_err),
        .data_out  (data_out),
        .rd_valid  (rd_valid),
        .busy      (busy),
        .par_err   (par_err),
        .err_count (err_count),
        .err_addr  (err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic [7:0] cnt;
        logic [4:0] a;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] m_data [32];
    logic       m_bad  [32];
    logic [7:0] exp_cnt;
    logic [4:0] exp_eaddr;
    logic [7:0] last_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Output monitor: every rd_valid pulse must match the oldest scoreboard entry
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rd_valid === 1'b1) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rd_data", 32'(data_out), 32'(e.d));
                chk("rd_par_err", 32'(par_err), 32'(e.pe));
                chk("rd_err_count", 32'(err_count), 32'(e.cnt));
                if (e.pe) chk("rd_err_addr", 32'(err_addr), 32'(e.a));
            end
        end else if (rst === 1'b0) begin
            chk("par_err_no_read", 32'(par_err), 32'd0);
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_data[i] = 8'h00;
            m_bad[i]  = 1'b0;
        end
        exp_cnt   = 8'd0;
        exp_eaddr = 5'd0;
        last_d    = 8'h00;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d, input logic inj);
        write   = 1'b1;
        addr    = a;
        data_in = d;
        inj_err = inj;
        m_data[a] = d;
        m_bad[a]  = PAR_ON && inj;
        @(negedge clk);
        write   = 1'b0;
        inj_err = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a);
        exp_t e;
        e.d  = m_data[a];
        e.pe = m_bad[a];
        if (e.pe) begin
            exp_eaddr = a;
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        end
        e.cnt  = exp_cnt;
        e.a    = a;
        last_d = m_data[a];
        sb.push_back(e);
        read = 1'b1;
        addr = a;
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (3) @(negedge clk);
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    // Reset, check reset outputs, then count busy cycles while hammering strobes that must be ignored
    task automatic do_reset();
        int n;
        rst = 1'b1; read = 1'b0; write = 1'b0; inj_err = 1'b0;
        addr = 5'd0; data_in = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_par_err", 32'(par_err), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_err_addr", 32'(err_addr), 32'd0);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            write   = n[0];
            read    = ~n[0];
            addr    = 5'(n);
            data_in = 8'hEE;
            inj_err = 1'b1;
            n++;
            @(negedge clk);
        end
        write = 1'b0; read = 1'b0; inj_err = 1'b0;
        chk("busy_cycles", 32'(n), 32'd32);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        for (int a = 0; a < 32; a++) rd(5'(a));
        drain("sb_empty_after_clear_reads");

        for (int a = 0; a < 32; a++) wr(5'(a), 8'(a), 1'b0);
        for (int a = 0; a < 32; a++) rd(5'(a));
        drain("sb_empty_after_readback");
        chk("err_count_clean", 32'(err_count), 32'd0);

        wr(5'd3, 8'hA5, 1'b1);
        rd(5'd3);
        drain("sb_empty_after_inject");
        chk("err_count_inject", 32'(err_count), 32'(exp_cnt));
        chk("err_addr_inject", 32'(err_addr), 32'(exp_eaddr));

        rd(5'd31);
        read = 1'b1; write = 1'b1; addr = 5'd7; data_in = 8'h3C; inj_err = 1'b0;
        m_data[7] = 8'h3C;
        m_bad[7]  = 1'b0;
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        chk("collide_no_rd_valid", 32'(rd_valid), 32'd0);
        chk("collide_data_hold", 32'(data_out), 32'(last_d));
        rd(5'd7);
        drain("sb_empty_after_collide");
        chk("collide_readback", 32'(data_out), 32'h3C);

        wr(5'd10, 8'hFF, 1'b0);
        rd(5'd10);
        drain("sb_empty_before_rst");
        do_reset();
        rd(5'd10);
        rd(5'd5);
        drain("sb_empty_after_rst");
        chk("err_count_after_rst", 32'(err_count), 32'd0);

        wr(5'd3, 8'hA5, 1'b1);
        for (int i = 0; i < 300; i++) rd(5'd3);
        drain("sb_empty_after_sat");
        chk("err_count_sat", 32'(err_count), 32'(exp_cnt));
        chk("err_count_sat_abs", 32'(err_count), PAR_ON ? 32'd255 : 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_array.md
# mem_array

Synchronous single-port 32×8 memory. It is the device driven by the memory test bench and sits directly downstream of it, accepting its `read`/`write`/`addr`/`data_in` strobes and returning `data_out`. After reset it self-clears every location through an internal sequencer. It optionally stores a parity bit per word and reports read-time parity errors.

## Interface
Parameters:
- `DEPTH`, default 32: number of words.
- `AW`, default 5: address width; must equal $clog2(DEPTH).
- `DW`, default 8: data width.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `read`, in, 1: read strobe.
- `write`, in, 1: write strobe.
- `addr`, in, AW: word address.
- `data_in`, in, DW: write data.
- `inj_err`, in, 1: with `write`, stores inverted parity (fault injection).
- `data_out`, out, DW: registered read data.
- `rd_valid`, out, 1: one-cycle pulse; `data_out` was updated this edge.
- `busy`, out, 1: clear sequence in progress; host strobes are ignored.
- `par_err`, out, 1: one-cycle pulse with `rd_valid` on a parity mismatch.
- `err_count`, out, 8: saturating parity-error count.
- `err_addr`, out, AW: address of the most recent parity error.

## Operation
- Two states:
  - CLEAR: a pointer walks 0 → DEPTH-1, writing 0 (parity 0) to one word per cycle.
  - READY: the array serves host strobes.
- CLEAR → READY when the pointer reaches DEPTH-1 and that word is written.
- `rst` while `rst` is high:
  - state forced to CLEAR, pointer 0;
  - `data_out`=0, `rd_valid`=0, `busy`=1, `par_err`=0, `err_count`=0, `err_addr`=0.
- A reset asserted mid-clear or mid-access restarts the clear sequence from 0.
- In CLEAR, `read`, `write` and `inj_err` are ignored; `data_out` holds.
- In READY:
  - `write`=1: `mem[addr]` ← `data_in`, `par[addr]` ← ^`data_in` ^ `inj_err`.
  - `read`=1, `write`=0: `data_out` ← `mem[addr]` and `rd_valid`=1.
    - Parity check: (^`mem[addr]` ^ `par[addr]`)=1 → `par_err`=1, `err_addr`←`addr`, `err_count`+1, saturating at 255.
  - `read`=1 and `write`=1 together: the write is performed; the read is dropped and `data_out` holds.
  - Neither strobe: `data_out` holds its last value; `rd_valid`=0.
- Out-of-range addresses cannot occur because DEPTH=2^AW; no wrap logic is required.

## Timing
- Write latency: the value is visible to a read issued on the cycle after the write edge.
- Read latency: one rising edge. The bench sets `read`/`addr` at the falling edge, and `data_out` is valid from the next rising edge until the next read.
- `busy` is high for exactly DEPTH cycles after `rst` deasserts and falls on the same edge the last clear write occurs.
- `rd_valid`, `par_err` and the `err_count` increment change on the same edge as `data_out`.
- Strobes are level-sampled every rising edge; holding `write` for N cycles produces N writes.

## Configuration
- Macro: `MEM_ARRAY_PARITY_EN`.
- Defined: a parity bit is stored per word (DW+1 bits stored) and checked as described above.
- Undefined:
  - storage is DW bits only;
  - `par_err` is tied 0, `err_count` and `err_addr` are tied 0;
  - `inj_err` is accepted but ignored.
- The port list is identical in both builds.

## Structure
- Package `mem_array_pkg` holds:
  - the state enum `mem_state_e` {CLEAR, READY};
  - default width constants `MEM_AW`=5, `MEM_DW`=8, `MEM_DEPTH`=32;
  - the error counter width constant `MEM_ERRW`=8.
- Sub-module `mem_clear_seq` holds the FSM and pointer. It outputs `busy`, `clr_we` and `clr_addr`, which are muxed onto the array write port ahead of host strobes.

## Test plan
- Reset then idle → `busy`=1 for exactly 32 cycles, then 0; reads of all 32 addresses return 00 with `rd_valid` pulsing and `par_err`=0.
- Write data=address to 0..31, then read back → `data_out`=address at every location, `err_count`=0.
- Write 8'hA5 to addr 3 with `inj_err`=1, then read addr 3 → `data_out`=A5, `par_err`=1, `err_addr`=3, `err_count`=1; in the parity-off build, `par_err`=0.
- `read`=`write`=1 at addr 7 with data 8'h3C → no `rd_valid`, `data_out` unchanged; a subsequent read of addr 7 returns 3C.
- Assert `rst` during READY after writing addr 10 = 8'hFF → `busy` reasserts for 32 cycles; addr 10 then reads 00 and `err_count`=0.
- 300 injected-error reads → `err_count` saturates at 255.
